// File: rtl/event_readout_arbiter_if.sv
`default_nettype none
// ============================================================================
// event_readout_arbiter_if
// ----------------------------------------------------------------------------
// Bus bundle around the event readout arbiter: read side of the counter
// (header) FIFO, read side of the data FIFO, and the byte stream towards the
// transmit sender.
//   cfifo_*  : counter FIFO read port (rden out of master, dout/valid/empty in)
//   dfifo_*  : data FIFO read port   (rden out of master, dout/valid/empty in)
//   tx_*     : byte stream, transfer when tx_valid && tx_ready
// master = arbiter view, slave = FIFO/sender environment view.
// Revision: 1.0  initial release
// ============================================================================
interface event_readout_arbiter_if;
  logic       cfifo_rden;
  logic [7:0] cfifo_dout;
  logic       cfifo_valid;
  logic       cfifo_empty;
  logic       dfifo_rden;
  logic [7:0] dfifo_dout;
  logic       dfifo_valid;
  logic       dfifo_empty;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sof;
  logic       tx_eof;

  modport master (
    output cfifo_rden, input cfifo_dout, input cfifo_valid, input cfifo_empty,
    output dfifo_rden, input dfifo_dout, input dfifo_valid, input dfifo_empty,
    output tx_data, output tx_valid, output tx_sof, output tx_eof, input tx_ready
  );

  modport slave (
    input cfifo_rden, output cfifo_dout, output cfifo_valid, output cfifo_empty,
    input dfifo_rden, output dfifo_dout, output dfifo_valid, output dfifo_empty,
    input tx_data, input tx_valid, input tx_sof, input tx_eof, output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/event_readout_arbiter.sv
`default_nettype none
// ============================================================================
// event_readout_arbiter
// ----------------------------------------------------------------------------
// Streams one event as bytes: HDR_BYTES header bytes from the counter FIFO,
// then DATA_LEN bytes from the data FIFO, then pulses evt_ack and waits for
// evt_ready to drop before accepting the next event. A 4-entry skid buffer
// sits between the 1-cycle-latency FIFO reads and the tx stream.
// Ports:
//   clk, rst_n     : read-domain clock, asynchronous active-low reset
//   enable         : allows a new event to start (sampled in IDLE only)
//   evt_ready      : level, next event's header is complete
//   data_len       : data byte count, latched at event start
//   bus (master)   : counter FIFO, data FIFO and tx stream signals
//   evt_ack        : one-cycle pulse once the event is fully sent
//   busy           : block is not IDLE
//   evt_sent_cnt   : completed events, wraps
//   proto_err      : sticky FIFO protocol error
// Revision: 1.0  initial release
// ============================================================================
module event_readout_arbiter #(
  parameter int HDR_BYTES = 32,
  parameter int LEN_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    evt_ready,
  input  logic [LEN_W-1:0]        data_len,
  event_readout_arbiter_if.master bus,
  output logic                    evt_ack,
  output logic                    busy,
  output logic [31:0]             evt_sent_cnt,
  output logic                    proto_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_DATA    = 3'd2,
    S_DRAIN   = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  // One extra bit so a full-scale data_len never wraps the issue counter.
  localparam logic [LEN_W:0] HDR_LEN = (LEN_W+1)'(HDR_BYTES);
  localparam logic [LEN_W:0] ONE     = {{LEN_W{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   issued, issued_inc, phase_len;
  logic             load_evt, clr_issued;
  logic             src_empty, room, issue, eof_tag;

  // Skid buffer entry: {data[7:0], sof, eof}
  logic [9:0]       fifo_mem [4];
  logic [1:0]       wr_ptr, rd_ptr;
  logic [2:0]       occ;
  logic [9:0]       head;
  logic             tx_vld;

  // Metadata for the single read that can be outstanding (1-cycle latency).
  logic             inflight, infl_dsrc, infl_eof, sof_pending;
  logic             src_valid;
  logic [7:0]       src_data;
  logic             push, pop, missing, stray;

  // ---------------------------------------------------------------- read issue
  always_comb begin
    src_empty  = (state == S_DATA) ? bus.dfifo_empty : bus.cfifo_empty;
    phase_len  = (state == S_DATA) ? {1'b0, len_q} : HDR_LEN;
    // Limit to 2 so the outstanding read plus this one always fit in 4 slots
    // even when tx_ready stays low.
    room       = ({1'b0, occ} + {3'b000, inflight}) <= 4'd2;
    issue      = ((state == S_HDR) || (state == S_DATA)) && !src_empty && room &&
                 (issued < phase_len);
    issued_inc = issued + ONE;
    eof_tag    = ((state == S_DATA) && (issued_inc == {1'b0, len_q})) ||
                 ((state == S_HDR) && (issued_inc == HDR_LEN) && (len_q == '0));
  end

  assign bus.cfifo_rden = issue && (state == S_HDR);
  assign bus.dfifo_rden = issue && (state == S_DATA);

  // ------------------------------------------------------------------ capture
  always_comb begin
    src_valid = infl_dsrc ? bus.dfifo_valid : bus.cfifo_valid;
    src_data  = infl_dsrc ? bus.dfifo_dout  : bus.cfifo_dout;
    push      = inflight && src_valid;
    missing   = inflight && !src_valid;
    // Any VALID that does not answer the outstanding read is dropped.
    stray     = (bus.cfifo_valid && !(inflight && !infl_dsrc)) ||
                (bus.dfifo_valid && !(inflight &&  infl_dsrc));
    pop       = tx_vld && bus.tx_ready;
  end

  // ------------------------------------------------------------------ tx side
  assign head         = fifo_mem[rd_ptr];
  assign tx_vld       = (occ != 3'd0);
  assign bus.tx_valid = tx_vld;
  assign bus.tx_data  = tx_vld ? head[9:2] : 8'h00;
  assign bus.tx_sof   = tx_vld && head[1];
  assign bus.tx_eof   = tx_vld && head[0];

  assign evt_ack = (state == S_ACK);
  assign busy    = (state != S_IDLE);

  // ------------------------------------------------------------- state logic
  always_comb begin
    state_nxt  = state;
    load_evt   = 1'b0;
    clr_issued = 1'b0;
    case (state)
      S_IDLE: begin
        if (evt_ready && enable) begin
          state_nxt  = S_HDR;
          load_evt   = 1'b1;
          clr_issued = 1'b1;
        end
      end
      // Leave on the cycle the final read issues so the next phase starts
      // reading immediately (no bubble at the header/data seam).
      S_HDR: begin
        if (issue && (issued_inc == HDR_LEN)) begin
          clr_issued = 1'b1;
          state_nxt  = (len_q == '0) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (issue && (issued_inc == {1'b0, len_q})) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((occ == 3'd0) && !inflight) state_nxt = S_ACK;
      end
      S_ACK:     state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (!evt_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_q        <= '0;
      issued       <= '0;
      evt_sent_cnt <= 32'd0;
      proto_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_evt) len_q <= data_len;
      if (clr_issued)  issued <= '0;
      else if (issue)  issued <= issued_inc;
      if (state == S_ACK) evt_sent_cnt <= evt_sent_cnt + 32'd1;
      if (missing || stray) proto_err <= 1'b1;
    end
  end

  // ------------------------------------------------------------ skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      occ         <= 3'd0;
      inflight    <= 1'b0;
      infl_dsrc   <= 1'b0;
      infl_eof    <= 1'b0;
      sof_pending <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_dsrc <= (state == S_DATA);
        infl_eof  <= eof_tag;
      end
      // SOF follows the first header byte actually captured.
      if (load_evt)                 sof_pending <= 1'b1;
      else if (push && !infl_dsrc)  sof_pending <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      occ <= occ + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {src_data, (!infl_dsrc && sof_pending), infl_eof};
  end

endmodule
`default_nettype wire

// File: tb/tb_event_readout_arbiter.sv
`default_nettype none
// ============================================================================
// tb_event_readout_arbiter
// ----------------------------------------------------------------------------
// Directed bench: FIFO source models, tx sink/monitor, and per-event checks
// of byte order, SOF/EOF placement, ack, counters and read throttling.
// Revision: 1.0  initial release
// ============================================================================
module tb_event_readout_arbiter;
  localparam int HDR = 32;
  localparam int LW  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          evt_ready;
  logic [LW-1:0] data_len;
  logic          evt_ack;
  logic          busy;
  logic [31:0]   evt_sent_cnt;
  logic          proto_err;

  event_readout_arbiter_if bus();

  event_readout_arbiter #(.HDR_BYTES(HDR), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .evt_ready    (evt_ready),
    .data_len     (data_len),
    .bus          (bus),
    .evt_ack      (evt_ack),
    .busy         (busy),
    .evt_sent_cnt (evt_sent_cnt),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------- FIFO source models
  logic [7:0] cq[$];
  logic [7:0] dq[$];
  logic [7:0] c_dout, d_dout;
  logic       c_valid, d_valid, c_empty_q, d_empty_q;
  logic       d_starve = 1'b0;
  int         d_pop_n = 0;
  int         d_drop_idx = -1;

  assign bus.cfifo_dout  = c_dout;
  assign bus.cfifo_valid = c_valid;
  assign bus.cfifo_empty = c_empty_q;
  assign bus.dfifo_dout  = d_dout;
  assign bus.dfifo_valid = d_valid;
  assign bus.dfifo_empty = d_empty_q || d_starve;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0; d_valid <= 1'b0; c_dout <= 8'h00; d_dout <= 8'h00;
      c_empty_q <= 1'b1; d_empty_q <= 1'b1;
    end else begin
      c_valid <= bus.cfifo_rden;
      if (bus.cfifo_rden && cq.size() > 0) c_dout <= cq.pop_front();
      d_valid <= bus.dfifo_rden && (d_pop_n != d_drop_idx);
      if (bus.dfifo_rden) begin
        if (dq.size() > 0) d_dout <= dq.pop_front();
        d_pop_n <= d_pop_n + 1;
      end
      c_empty_q <= (cq.size() == 0);
      d_empty_q <= (dq.size() == 0);
    end
  end

  // --------------------------------------------------------- tx sink/monitor
  bit         bp_mode = 1'b0;
  int         cyc = 0, ack_cnt = 0, ack_cyc = 0, rden_cnt = 0, drden_cnt = 0;
  int         room_viol = 0, occ_m = 0, infl_m = 0;
  logic [7:0] rx_data[$];
  logic [1:0] rx_flag[$];
  int         rx_cyc[$];

  always @(posedge clk) begin
    #1;
    bus.tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      occ_m  = 0;
      infl_m = 0;
    end else begin
      if (bus.cfifo_rden || bus.dfifo_rden) begin
        rden_cnt++;
        if (occ_m + infl_m > 2) room_viol++;
      end
      if (bus.dfifo_rden) drden_cnt++;
      if (evt_ack) begin ack_cnt++; ack_cyc = cyc; end
      if (bus.tx_valid && bus.tx_ready) begin
        rx_data.push_back(bus.tx_data);
        rx_flag.push_back({bus.tx_sof, bus.tx_eof});
        rx_cyc.push_back(cyc);
      end
      occ_m = occ_m + (((infl_m != 0) && (bus.cfifo_valid || bus.dfifo_valid)) ? 1 : 0)
                    - ((bus.tx_valid && bus.tx_ready) ? 1 : 0);
      infl_m = (bus.cfifo_rden || bus.dfifo_rden) ? 1 : 0;
    end
    cyc++;
  end

  // ----------------------------------------------------------------- checking
  int n_chk = 0;
  int n_err = 0;
  int exp_sent = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Loads both FIFOs, runs one event, and checks the received stream.
  // skip: data index whose VALID is suppressed (-1 = none).
  task automatic do_event(input string tag, input int dlen, input int skip,
                          input bit bp, input bit tchk, input int hold);
    int base, ack0, viol0, drd0, rd0, t, bad, nsof, neof, n;
    logic [7:0] exp_q[$];
    for (int i = 0; i < HDR; i++) begin
      cq.push_back(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int i = 0; i < dlen; i++) begin
      dq.push_back(8'(8'hA0 + i));
      if (i != skip) exp_q.push_back(8'(8'hA0 + i));
    end
    base  = rx_data.size();
    ack0  = ack_cnt;
    viol0 = room_viol;
    drd0  = drden_cnt;
    bp_mode   = bp;
    data_len  = 16'(dlen);
    evt_ready = 1'b1;
    t = 0;
    while (ack_cnt == ack0 && t < 4000) begin @(negedge clk); t++; end
    check({tag, " ack"}, 32'(ack_cnt - ack0), 32'd1);
    exp_sent++;
    if (hold > 0) begin
      rd0 = rden_cnt;
      repeat (hold) @(negedge clk);
      check({tag, " hold rden"}, 32'(rden_cnt - rd0), 32'd0);
      check({tag, " hold ack"}, 32'(ack_cnt - ack0), 32'd1);
      check({tag, " hold busy"}, 32'(busy), 32'd1);
    end
    evt_ready = 1'b0;
    t = 0;
    while (busy && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    bp_mode = 1'b0;
    n = rx_data.size() - base;
    check({tag, " rx len"}, 32'(n), 32'(exp_q.size()));
    bad = 0; nsof = 0; neof = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (rx_data[base+i] !== exp_q[i]) bad++;
      if (rx_flag[base+i][1]) nsof++;
      if (rx_flag[base+i][0]) neof++;
    end
    check({tag, " bytes"}, 32'(bad), 32'd0);
    check({tag, " sof first"}, 32'(rx_flag[base][1]), 32'd1);
    check({tag, " sof count"}, 32'(nsof), 32'd1);
    check({tag, " eof last"}, 32'(rx_flag[base+n-1][0]), 32'd1);
    check({tag, " eof count"}, 32'(neof), 32'd1);
    check({tag, " sent cnt"}, evt_sent_cnt, 32'(exp_sent));
    check({tag, " room"}, 32'(room_viol - viol0), 32'd0);
    check({tag, " ack latency"}, 32'(ack_cyc - rx_cyc[base+n-1]), 32'd2);
    if (dlen == 0) check({tag, " dfifo rden"}, 32'(drden_cnt - drd0), 32'd0);
    if (tchk) check({tag, " span"}, 32'(rx_cyc[base+n-1] - rx_cyc[base]), 32'(n - 1));
  endtask

  // ----------------------------------------------------------------- stimulus
  int drd_base, starve_rd, base, t, rd0;

  initial begin
    rst_n = 1'b0; enable = 1'b0; evt_ready = 1'b0; data_len = '0;
    repeat (3) @(negedge clk);
    check("reset busy",       32'(busy),           32'd0);
    check("reset tx_valid",   32'(bus.tx_valid),   32'd0);
    check("reset tx_data",    32'(bus.tx_data),    32'd0);
    check("reset sof/eof",    32'({bus.tx_sof, bus.tx_eof}), 32'd0);
    check("reset rden",       32'({bus.cfifo_rden, bus.dfifo_rden}), 32'd0);
    check("reset evt_ack",    32'(evt_ack),        32'd0);
    check("reset sent cnt",   evt_sent_cnt,        32'd0);
    check("reset proto_err",  32'(proto_err),      32'd0);
    rst_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);

    do_event("single",       8, -1, 1'b0, 1'b1, 0);
    do_event("backpressure", 8, -1, 1'b1, 1'b0, 0);
    do_event("zero length",  0, -1, 1'b0, 1'b1, 0);
    do_event("release",      4, -1, 1'b0, 1'b1, 50);
    do_event("second",       4, -1, 1'b0, 1'b1, 0);

    // Data FIFO runs dry for 20 cycles partway through the data phase.
    drd_base  = drden_cnt;
    starve_rd = 0;
    fork
      do_event("starve", 8, -1, 1'b0, 1'b0, 0);
      begin
        int w;
        w = 0;
        while (drden_cnt < drd_base + 3 && w < 2000) begin @(negedge clk); w++; end
        d_starve = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (bus.dfifo_rden) starve_rd++;
        end
        d_starve = 1'b0;
      end
    join
    check("starve rden", 32'(starve_rd), 32'd0);
    check("starve proto_err", 32'(proto_err), 32'd0);

    // Data byte 3 comes back without VALID.
    d_drop_idx = d_pop_n + 3;
    do_event("missing valid", 8, 3, 1'b0, 1'b0, 0);
    check("missing valid proto_err", 32'(proto_err), 32'd1);

    // Reset in the middle of an event.
    for (int i = 0; i < HDR; i++) cq.push_back(8'(i));
    for (int i = 0; i < 8; i++) dq.push_back(8'(8'hA0 + i));
    base = rx_data.size();
    data_len = 16'd8;
    evt_ready = 1'b1;
    t = 0;
    while (rx_data.size() < base + 10 && t < 500) begin @(negedge clk); t++; end
    check("midrst reached 10 bytes", 32'(rx_data.size() >= base + 10), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy",      32'(busy),         32'd0);
    check("midrst tx_valid",  32'(bus.tx_valid), 32'd0);
    check("midrst tx_data",   32'(bus.tx_data),  32'd0);
    check("midrst rden",      32'({bus.cfifo_rden, bus.dfifo_rden}), 32'd0);
    check("midrst sent cnt",  evt_sent_cnt,      32'd0);
    check("midrst proto_err", 32'(proto_err),    32'd0);
    @(negedge clk);
    cq.delete();
    dq.delete();
    enable   = 1'b0;
    exp_sent = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = rden_cnt;
    repeat (10) @(negedge clk);
    check("post reset idle busy", 32'(busy), 32'd0);
    check("post reset idle rden", 32'(rden_cnt - rd0), 32'd0);
    evt_ready = 1'b0;
    enable    = 1'b1;
    repeat (2) @(negedge clk);
    do_event("after reset", 8, -1, 1'b0, 1'b1, 0);
    check("final proto_err", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Absolute time limit in case an event never completes.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/event_readout_arbiter.md
# event_readout_arbiter

Sequences one event's readout into a single byte stream for the transmit interface. It first drains the fixed-length counter/header FIFO (32 bytes per event), then the DRS waveform data FIFO (a runtime byte count), and then acknowledges the event to DRS control. It sits in the FIFO read-clock domain, between the counter FIFO, the data FIFO and the TCP/UDP sender.

## Interface
Parameters:
- HDR_BYTES, 32: header bytes read from the counter FIFO per event (16 words × 2 bytes).
- LEN_W, 16: width of the data byte count.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  read-domain clock.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  permits starting a new event; sampled only in IDLE.
- EVT_READY  in  1  level; header for the next event is complete in the counter FIFO.
- DATA_LEN  in  LEN_W  data bytes per event; latched on event start.
- CFIFO_RDEN  out  1  counter FIFO read strobe.
- CFIFO_DOUT  in  8  counter FIFO data.
- CFIFO_VALID  in  1  counter FIFO data valid.
- CFIFO_EMPTY  in  1  counter FIFO has no byte available.
- DFIFO_RDEN  out  1  data FIFO read strobe.
- DFIFO_DOUT  in  8  data FIFO data.
- DFIFO_VALID  in  1  data FIFO data valid.
- DFIFO_EMPTY  in  1  data FIFO has no byte available.
- TX_DATA  out  8  output byte.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  sink accepts the byte; a transfer occurs when TX_VALID and TX_READY are both high.
- TX_SOF  out  1  qualifies the first header byte.
- TX_EOF  out  1  qualifies the last byte of the event.
- EVT_ACK  out  1  one-cycle pulse when the event has been fully sent.
- BUSY  out  1  high in any state other than IDLE.
- EVT_SENT_CNT  out  32  number of completed events; wraps at 2^32.
- PROTO_ERR  out  1  sticky FIFO protocol error; cleared only by reset.

## Operation
- **Source read timing:** both sources are standard FIFOs with 1-cycle read latency. VALID is expected exactly one cycle after RDEN.
- **Skid buffer:** a 4-entry buffer, 10 bits per entry (data, SOF, EOF), feeds TX. TX_DATA, TX_SOF and TX_EOF come from the buffer head. TX_VALID is high when the buffer is not empty.
- **Read issue rule:** RDEN (combinational) is issued to the active source when all of the following hold:
  - the source is not EMPTY;
  - buffer occupancy + reads in flight ≤ 2;
  - issued count < phase length.
- **Capture:** a byte is written to the buffer on the active source's VALID. This gives 1 byte/cycle sustained with TX_READY held high, and no overflow under any TX_READY pattern.
- **States:**
  - **IDLE:** when EVT_READY=1 and ENABLE=1, latch DATA_LEN, clear the issued counter, go to HDR.
  - **HDR:** issue CFIFO reads. When issued = HDR_BYTES, clear the counter and go to DATA; go to DRAIN instead if the latched length is 0.
  - **DATA:** issue DFIFO reads. When issued = latched length, go to DRAIN.
  - **DRAIN:** when the buffer is empty and no read is in flight, go to ACK.
  - **ACK:** EVT_ACK=1 for this single cycle, EVT_SENT_CNT+1, go to RELEASE.
  - **RELEASE:** wait for EVT_READY=0 (DRS control clears its done flag), then go to IDLE. This prevents re-reading the same event.
- **SOF/EOF tagging:**
  - SOF is tagged on the first captured header byte.
  - EOF is tagged on the last captured data byte, or on header byte HDR_BYTES-1 when the length is 0.
- **ENABLE:** deasserting ENABLE mid-event does not abort; the event completes.
- **PROTO_ERR:** set on either condition below; the buffer state is unaffected.
  - VALID is absent in the cycle after RDEN. The byte is not captured; the event still ends by count, and EOF stays on the last captured byte.
  - VALID is asserted with no read in flight. The data is dropped.
- **Reset:** asserting RST_N low at any time (including mid-event) returns the block to IDLE and flushes the buffer and counters.

## Timing
- **Reset values:** all outputs 0 (CFIFO_RDEN, DFIFO_RDEN, TX_DATA, TX_VALID, TX_SOF, TX_EOF, EVT_ACK, BUSY, EVT_SENT_CNT, PROTO_ERR).
- **Start latency:** EVT_READY sampled high at edge t0 → state HDR from t0 → first CFIFO_RDEN in cycle t0+1.
- **Read-to-output latency:** RDEN in cycle t → VALID in t+1 → byte at TX_VALID in cycle t+2.
- **Event length:** with TX_READY=1 and sources never empty, TX_VALID is continuous for HDR_BYTES+DATA_LEN cycles. The HDR→DATA switch adds no bubble.
- **EVT_ACK:** the pulse occurs 2 cycles after the cycle in which the EOF byte is accepted (DRAIN detects empty, then ACK).
- **Back-pressure:** TX_READY low holds TX_DATA/TX_VALID stable. Reads continue until occupancy + in-flight reaches 3, then stop.
- **Counter width:** the issued counter is LEN_W+1 bits. DATA_LEN = 2^LEN_W−1 must complete without wrap.

## Test plan
- **Single event:** reset, ENABLE=1, CFIFO preloaded with 32 bytes 0x00..0x1F, DFIFO with 8 bytes 0xA0..0xA7, DATA_LEN=8, TX_READY=1, EVT_READY raised → 40 consecutive TX bytes in order; SOF on 0x00, EOF on 0xA7; one EVT_ACK; EVT_SENT_CNT=1.
- **Back-pressure:** same event with TX_READY toggled in a 1-of-3 pattern → identical 40-byte sequence, no loss or duplication; RDEN never issued when occupancy + in-flight = 3.
- **Zero length:** DATA_LEN=0 → 32 bytes, EOF on header byte 31, DFIFO_RDEN never asserted, EVT_ACK pulses once.
- **Release handshake:** EVT_READY held high for 50 cycles after EVT_ACK → no second event and no RDEN. EVT_READY dropped then raised again → second event starts; EVT_SENT_CNT=2.
- **Source starvation:** DFIFO_EMPTY=1 for 20 cycles mid-data → DFIFO_RDEN held low, TX_VALID gaps, stream resumes correctly. Injecting a missing VALID instead sets PROTO_ERR=1.
- **Reset mid-event:** RST_N pulsed low after 10 bytes → all outputs 0 immediately, BUSY=0. After release, a new event starts only on EVT_READY with ENABLE=1.
